// File: rtl/burst_rd_pkg.sv
// Shared types and helpers for the burst read master: state encoding and
// width/size helper functions.
package burst_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        REQ,
        DATA,
        DONE
    } brm_state_t;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
        return (num + den - 64'd1) / den;
    endfunction

endpackage

// File: rtl/burst_sizer.sv
// Holds the current burst address and length; loads them from the packet base
// and advances them after each accepted burst. Define BURST_RD_MASTER_BOUNDARY_EN
// to keep bursts inside MAX_BURST*BYTES-aligned windows.
module burst_sizer #(
    parameter int ADDR_W    = 32,
    parameter int BCNT_W    = 16,
    parameter int BYTES     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] words_i,
    input  logic [ADDR_W-1:0] rem_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BCNT_W-1:0] bc_o
);

    localparam int WSH = $clog2(BYTES);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BCNT_W-1:0] bc_q, bc_d;
    logic [ADDR_W-1:0] rem_src, lim, size;

    always_comb begin
        // rem_i still includes the burst being accepted, so subtract it here
        addr_d  = addr_q + (ADDR_W'(bc_q) << WSH);
        rem_src = rem_i - ADDR_W'(bc_q);
        if (load_i) begin
            addr_d  = base_i;
            rem_src = words_i;
        end
        lim = ADDR_W'(MAX_BURST);
`ifdef BURST_RD_MASTER_BOUNDARY_EN
        lim = ADDR_W'(MAX_BURST) - ((addr_d >> WSH) & ADDR_W'(MAX_BURST - 1));
`endif
        size = (rem_src < lim) ? rem_src : lim;
        bc_d = BCNT_W'(size);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
            bc_q   <= '0;
        end else if (load_i || adv_i) begin
            addr_q <= addr_d;
            bc_q   <= bc_d;
        end
    end

    assign addr_o = addr_q;
    assign bc_o   = bc_q;

endmodule

// File: rtl/burst_rd_master.sv
// Avalon-MM burst read master streaming [pkt_begin, pkt_end) into a capture FIFO
// with first/last/offset/empty framing. Option: BURST_RD_MASTER_BOUNDARY_EN.
module burst_rd_master
    import burst_rd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int BCNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [ADDR_W-1:0]                   pkt_begin,
    input  logic [ADDR_W-1:0]                   pkt_end,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    input  logic                                fifo_almost_full,
    output logic                                fifo_wr,
    output logic [DATA_W-1:0]                   fifo_data,
    output logic                                fifo_first,
    output logic                                fifo_last,
    output logic [off_w_of(DATA_W)-1:0]         fifo_offset,
    output logic [off_w_of(DATA_W)-1:0]         fifo_empty,
    output logic [ADDR_W-1:0]                   avm_address,
    output logic                                avm_read,
    output logic [BCNT_W-1:0]                   avm_burstcount,
    input  logic [DATA_W-1:0]                   avm_readdata,
    input  logic                                avm_readdatavalid,
    input  logic                                avm_waitrequest
);

    localparam int BYTES = bytes_of(DATA_W);
    localparam int OFF_W = off_w_of(DATA_W);

    brm_state_t state_q, state_d;

    logic [ADDR_W-1:0] beg_q, end_q, rem_q, left_q;
    logic [OFF_W-1:0]  off_q, empty_q;
    logic [BCNT_W-1:0] cnt_q;
    logic              err_q, first_q, hold_q;
    logic              fifo_wr_q, fifo_first_q, fifo_last_q;
    logic [DATA_W-1:0] fifo_data_q;
    logic [OFF_W-1:0]  fifo_offset_q, fifo_empty_q;

    logic [OFF_W-1:0]  calc_off, calc_empty;
    logic [ADDR_W-1:0] calc_base, calc_len, calc_tot, calc_words;
    logic              calc_err, rd_acc, beat;

    always_comb begin
        calc_off   = beg_q[OFF_W-1:0];
        calc_base  = {beg_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        calc_len   = end_q - beg_q;
        calc_tot   = ADDR_W'(calc_off) + calc_len;
        calc_words = ADDR_W'(ceil_div(64'(calc_tot), 64'(BYTES)));
        calc_empty = (~calc_tot[OFF_W-1:0]) + OFF_W'(1);
        calc_err   = (end_q < beg_q);
    end

    // Once a request is stalled it must stay up even if the FIFO fills meanwhile
    assign avm_read = reset && (state_q == REQ) && (hold_q || !fifo_almost_full);
    assign rd_acc   = avm_read && !avm_waitrequest;
    assign beat     = (state_q == DATA) && avm_readdatavalid && (cnt_q != '0);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = done && err_q;

    burst_sizer #(
        .ADDR_W   (ADDR_W),
        .BCNT_W   (BCNT_W),
        .BYTES    (BYTES),
        .MAX_BURST(MAX_BURST)
    ) u_sizer (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == CALC),
        .adv_i  (rd_acc),
        .base_i (calc_base),
        .words_i(calc_words),
        .rem_i  (rem_q),
        .addr_o (avm_address),
        .bc_o   (avm_burstcount)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: begin
                if (calc_err || calc_len == '0) state_d = DONE;
                else                             state_d = REQ;
            end
            REQ:  if (rd_acc) state_d = DATA;
            DATA: begin
                // done must trail the write carrying fifo_last by one cycle
                if (beat && cnt_q == BCNT_W'(1) && rem_q != '0) state_d = REQ;
                else if (fifo_wr_q && fifo_last_q)               state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            beg_q         <= '0;
            end_q         <= '0;
            rem_q         <= '0;
            left_q        <= '0;
            off_q         <= '0;
            empty_q       <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            first_q       <= 1'b0;
            hold_q        <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_first_q  <= 1'b0;
            fifo_last_q   <= 1'b0;
            fifo_data_q   <= '0;
            fifo_offset_q <= '0;
            fifo_empty_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= avm_read && avm_waitrequest;
            fifo_wr_q    <= beat;
            fifo_first_q <= beat && first_q;
            fifo_last_q  <= beat && (left_q == ADDR_W'(1));
            if (state_q == IDLE && start) begin
                beg_q <= pkt_begin;
                end_q <= pkt_end;
            end
            if (state_q == CALC) begin
                off_q   <= calc_off;
                empty_q <= calc_empty;
                rem_q   <= calc_words;
                left_q  <= calc_words;
                err_q   <= calc_err;
                first_q <= 1'b1;
            end
            if (rd_acc) begin
                cnt_q <= avm_burstcount;
                rem_q <= rem_q - ADDR_W'(avm_burstcount);
            end
            if (beat) begin
                cnt_q         <= cnt_q - BCNT_W'(1);
                left_q        <= left_q - ADDR_W'(1);
                first_q       <= 1'b0;
                fifo_data_q   <= avm_readdata;
                fifo_offset_q <= first_q ? off_q : '0;
                fifo_empty_q  <= (left_q == ADDR_W'(1)) ? empty_q : '0;
            end
        end
    end

    assign fifo_wr     = fifo_wr_q;
    assign fifo_data   = fifo_data_q;
    assign fifo_first  = fifo_first_q;
    assign fifo_last   = fifo_last_q;
    assign fifo_offset = fifo_offset_q;
    assign fifo_empty  = fifo_empty_q;

endmodule

// File: tb/tb_burst_rd_master.sv
// Directed bench for burst_rd_master: Avalon slave model, FIFO/done monitor and
// hand-computed packet expectations (DATA_W=32, MAX_BURST=16).
module tb_burst_rd_master;

    logic        clk, reset, start;
    logic [31:0] pkt_begin, pkt_end;
    logic        busy, done, err;
    logic        fifo_almost_full, fifo_wr, fifo_first, fifo_last;
    logic [31:0] fifo_data;
    logic [1:0]  fifo_offset, fifo_empty;
    logic [31:0] avm_address, avm_readdata;
    logic        avm_read, avm_readdatavalid, avm_waitrequest;
    logic [15:0] avm_burstcount;

    burst_rd_master #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(16), .BCNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .pkt_begin        (pkt_begin),
        .pkt_end          (pkt_end),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr          (fifo_wr),
        .fifo_data        (fifo_data),
        .fifo_first       (fifo_first),
        .fifo_last        (fifo_last),
        .fifo_offset      (fifo_offset),
        .fifo_empty       (fifo_empty),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_burstcount   (avm_burstcount),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest  (avm_waitrequest)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0, first_rd, rd_seen, beats_left;
    bit rand_wait, prev_pend;
    logic [31:0] baddr, prev_a;
    logic [15:0] prev_bc;

    logic [31:0] w_data[$];
    bit          w_first[$], w_last[$];
    logic [1:0]  w_off[$], w_emp[$];
    int          w_cyc[$], d_cyc[$];
    bit          d_err[$];
    logic [31:0] b_addr[$];
    logic [15:0] b_bc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Avalon slave: one burst at a time, data is a function of the word address
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        beats_left = 0;
        baddr = '0;
        prev_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (beats_left > 0 && !(rand_wait && $urandom_range(0, 3) == 0)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = pat(baddr);
                baddr = baddr + 32'd4;
                beats_left--;
            end else begin
                avm_readdatavalid = 1'b0;
            end
            avm_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
            #1;
            if (prev_pend) begin
                chk("stall/read", avm_read, 1);
                chk("stall/addr", avm_address, prev_a);
                chk("stall/bc", avm_burstcount, prev_bc);
            end
            prev_pend = avm_read && avm_waitrequest;
            prev_a = avm_address;
            prev_bc = avm_burstcount;
            if (avm_read && !avm_waitrequest) begin
                b_addr.push_back(avm_address);
                b_bc.push_back(avm_burstcount);
                baddr = avm_address;
                beats_left = int'(avm_burstcount);
            end
        end
    end

    // FIFO / status monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (fifo_wr) begin
                w_data.push_back(fifo_data);
                w_first.push_back(fifo_first);
                w_last.push_back(fifo_last);
                w_off.push_back(fifo_offset);
                w_emp.push_back(fifo_empty);
                w_cyc.push_back(cyc);
            end
            if (done) begin
                d_cyc.push_back(cyc);
                d_err.push_back(err);
            end
            if (avm_read) begin
                rd_seen++;
                if (first_rd < 0) first_rd = cyc;
            end
        end
    end

    task automatic go(input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        w_data.delete(); w_first.delete(); w_last.delete(); w_off.delete();
        w_emp.delete(); w_cyc.delete(); d_cyc.delete(); d_err.delete();
        b_addr.delete(); b_bc.delete();
        rd_seen = 0;
        first_rd = -1;
        pkt_begin = b;
        pkt_end = e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            #3;
            if (d_cyc.size() > 0) break;
        end
        repeat (4) @(negedge clk);
        #3;
        $display("%s: %0d writes, %0d bursts, %0d done pulses", nm, w_data.size(), b_addr.size(), d_cyc.size());
    endtask

    task automatic check_pkt(input string nm, input logic [31:0] base, input int nw,
                             input int off, input int emp);
        chk({nm, "/n_wr"}, w_data.size(), nw);
        for (int i = 0; i < w_data.size() && i < nw; i++) begin
            chk({nm, "/data"}, w_data[i], pat(base + 32'(4 * i)));
            chk({nm, "/first"}, w_first[i], (i == 0));
            chk({nm, "/last"}, w_last[i], (i == nw - 1));
            if (i == 0) chk({nm, "/offset"}, w_off[i], off);
            if (i == nw - 1) chk({nm, "/empty"}, w_emp[i], emp);
        end
        chk({nm, "/n_done"}, d_cyc.size(), 1);
        if (d_cyc.size() > 0 && w_cyc.size() > 0) begin
            chk({nm, "/done_lat"}, d_cyc[0], w_cyc[w_cyc.size() - 1] + 1);
            chk({nm, "/err"}, d_err[0], 0);
        end
    endtask

    task automatic check_burst(input string nm, input int idx, input logic [31:0] a, input int bc);
        if (b_addr.size() > idx) begin
            chk({nm, "/addr"}, b_addr[idx], a);
            chk({nm, "/bc"}, b_bc[idx], bc);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pkt_begin = '0;
        pkt_end = '0;
        fifo_almost_full = 1'b0;
        rand_wait = 1'b0;
        first_rd = -1;
        rd_seen = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/err", err, 0);
        chk("rst/read", avm_read, 0);
        chk("rst/fifo_wr", fifo_wr, 0);
        chk("rst/first", fifo_first, 0);
        chk("rst/last", fifo_last, 0);
        chk("rst/addr", avm_address, 0);
        chk("rst/bc", avm_burstcount, 0);
        chk("rst/data", fifo_data, 0);
        chk("rst/offset", fifo_offset, 0);
        chk("rst/empty", fifo_empty, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // aligned single burst
        go(32'h1000, 32'h1040);
        wait_done("t1");
        chk("t1/first_rd_lat", first_rd - t0, 1);
        chk("t1/n_bursts", b_addr.size(), 1);
        check_burst("t1/b0", 0, 32'h1000, 16);
        check_pkt("t1", 32'h1000, 16, 0, 0);

        // unaligned head and tail: off 2, 18 words, empty 1
        go(32'h1002, 32'h1047);
        wait_done("t2");
        chk("t2/n_bursts", b_addr.size(), 2);
        check_burst("t2/b0", 0, 32'h1000, 16);
        check_burst("t2/b1", 1, 32'h1040, 2);
        check_pkt("t2", 32'h1000, 18, 2, 1);

        // boundary option
        go(32'h1030, 32'h1070);
        wait_done("t3");
`ifdef BURST_RD_MASTER_BOUNDARY_EN
        chk("t3/n_bursts", b_addr.size(), 2);
        check_burst("t3/b0", 0, 32'h1030, 4);
        check_burst("t3/b1", 1, 32'h1040, 12);
`else
        chk("t3/n_bursts", b_addr.size(), 1);
        check_burst("t3/b0", 0, 32'h1030, 16);
`endif
        check_pkt("t3", 32'h1030, 16, 0, 0);

        // FIFO almost full held, then random waitrequest and data gaps
        fifo_almost_full = 1'b1;
        go(32'h2000, 32'h2080);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            #3;
            chk("t4/af_no_read", avm_read, 0);
        end
        @(negedge clk);
        fifo_almost_full = 1'b0;
        rand_wait = 1'b1;
        wait_done("t4");
        rand_wait = 1'b0;
        chk("t4/n_bursts", b_addr.size(), 2);
        check_burst("t4/b0", 0, 32'h2000, 16);
        check_burst("t4/b1", 1, 32'h2040, 16);
        check_pkt("t4", 32'h2000, 32, 0, 0);

        // zero length
        go(32'h300, 32'h300);
        wait_done("t5");
        chk("t5/n_done", d_cyc.size(), 1);
        if (d_cyc.size() > 0) begin
            chk("t5/done_lat", d_cyc[0] - t0, 1);
            chk("t5/err", d_err[0], 0);
        end
        chk("t5/reads", rd_seen, 0);
        chk("t5/n_wr", w_data.size(), 0);

        // end before begin
        go(32'h20, 32'h10);
        wait_done("t6");
        chk("t6/n_done", d_cyc.size(), 1);
        if (d_cyc.size() > 0) begin
            chk("t6/done_lat", d_cyc[0] - t0, 1);
            chk("t6/err", d_err[0], 1);
        end
        chk("t6/reads", rd_seen, 0);
        chk("t6/n_wr", w_data.size(), 0);

        // reset during beat 5; remaining beats arrive as strays
        go(32'h1000, 32'h1040);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (w_data.size() >= 4) break;
        end
        chk("t7/pre_wr", w_data.size(), 4);
        reset = 1'b0;
        #1;
        chk("t7/read_low", avm_read, 0);
        @(negedge clk);
        #3;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #3;
        $display("t7: reset mid-burst, %0d writes, %0d done pulses", w_data.size(), d_cyc.size());
        chk("t7/post_wr", w_data.size(), 4);
        chk("t7/no_done", d_cyc.size(), 0);
        chk("t7/busy", busy, 0);

        go(32'h1002, 32'h1047);
        wait_done("t8");
        chk("t8/n_bursts", b_addr.size(), 2);
        check_burst("t8/b0", 0, 32'h1000, 16);
        check_burst("t8/b1", 1, 32'h1040, 2);
        check_pkt("t8", 32'h1000, 18, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
